// File: rtl/wt_dcache_ship_tracker.sv
// Per-line signature/outcome tracking for the write-through dcache, producing
// registered hit and eviction training events for the SHCT predictor.
module wt_dcache_ship_tracker #(
   parameter int unsigned NumSets = 256,
   parameter int unsigned NumWays = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       acc_valid_i,
   input  logic [$clog2(NumSets)-1:0] acc_set_i,
   input  logic [$clog2(NumWays)-1:0] acc_way_i,
   input  logic                       fill_valid_i,
   input  logic [$clog2(NumSets)-1:0] fill_set_i,
   input  logic [$clog2(NumWays)-1:0] fill_way_i,
   input  logic [63:0]                fill_pc_i,
   output logic                       fill_ready_o,
   input  logic                       inv_valid_i,
   input  logic [$clog2(NumSets)-1:0] inv_set_i,
   input  logic [$clog2(NumWays)-1:0] inv_way_i,
   output logic                       pred_hit_o,
   output logic                       pred_miss_o,
   output logic                       pred_outcome_o,
   output logic [13:0]                pred_hit_shct_o,
   output logic [13:0]                pred_miss_shct_o,
   output logic [13:0]                pred_shct_o
);
   localparam int unsigned SetW = $clog2(NumSets);
   localparam int unsigned WayW = $clog2(NumWays);

   typedef logic [13:0] sig_t;

   logic valid_q   [NumSets][NumWays];
   sig_t sig_q     [NumSets][NumWays];
   logic outcome_q [NumSets][NumWays];

   logic pend_valid_q;
   sig_t pend_sig_q;
   logic pend_out_q;

   sig_t            fill_sig;
   logic            unused_pc_bits;
   logic            hit;
   sig_t            hit_sig;
   logic            fill_acc;
   logic            inv_act;
   logic            ev_valid;
   logic [SetW-1:0] ev_set;
   logic [WayW-1:0] ev_way;
   sig_t            ev_sig;
   logic            ev_same;
   logic            ev_out;
   logic            miss_emit;
   sig_t            miss_sig;
   logic            miss_out;
   logic            park;
   sig_t            park_sig;
   logic            park_out;

   assign fill_sig       = fill_pc_i[15:2] ^ fill_pc_i[29:16];
   assign pred_shct_o    = fill_sig;
   assign unused_pc_bits = ^{fill_pc_i[63:30], fill_pc_i[1:0]};

   assign hit     = acc_valid_i && valid_q[acc_set_i][acc_way_i];
   assign hit_sig = sig_q[acc_set_i][acc_way_i];

   // A fill competing with an invalidation of another line loses the single eviction slot.
   assign fill_ready_o = !pend_valid_q &&
                         !(fill_valid_i && inv_valid_i &&
                           ((fill_set_i != inv_set_i) || (fill_way_i != inv_way_i)));
   assign fill_acc     = fill_valid_i && fill_ready_o;
   assign inv_act      = inv_valid_i && !pend_valid_q;

   always_comb begin
      ev_set   = fill_set_i;
      ev_way   = fill_way_i;
      ev_valid = 1'b0;
      if (fill_acc) begin
         ev_valid = valid_q[fill_set_i][fill_way_i];
      end else if (inv_act) begin
         ev_set   = inv_set_i;
         ev_way   = inv_way_i;
         ev_valid = valid_q[inv_set_i][inv_way_i];
      end
   end

   assign ev_sig  = sig_q[ev_set][ev_way];
   assign ev_same = hit && (acc_set_i == ev_set) && (acc_way_i == ev_way);
   assign ev_out  = outcome_q[ev_set][ev_way] | ev_same;

   // Equal signatures on distinct lines would alias in the predictor, so the eviction waits.
   always_comb begin
      miss_emit = 1'b0;
      miss_sig  = '0;
      miss_out  = 1'b0;
      park      = 1'b0;
      park_sig  = pend_sig_q;
      park_out  = pend_out_q;
      if (pend_valid_q) begin
         if (hit && (hit_sig == pend_sig_q)) begin
            park = 1'b1;
         end else begin
            miss_emit = 1'b1;
            miss_sig  = pend_sig_q;
            miss_out  = pend_out_q;
         end
      end else if (ev_valid) begin
         if (hit && (hit_sig == ev_sig) && !ev_same) begin
            park     = 1'b1;
            park_sig = ev_sig;
            park_out = ev_out;
         end else begin
            miss_emit = 1'b1;
            miss_sig  = ev_sig;
            miss_out  = ev_out;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned s = 0; s < NumSets; s++) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
               valid_q[s][w]   <= 1'b0;
               sig_q[s][w]     <= '0;
               outcome_q[s][w] <= 1'b0;
            end
         end
         pend_valid_q     <= 1'b0;
         pend_sig_q       <= '0;
         pend_out_q       <= 1'b0;
         pred_hit_o       <= 1'b0;
         pred_hit_shct_o  <= '0;
         pred_miss_o      <= 1'b0;
         pred_miss_shct_o <= '0;
         pred_outcome_o   <= 1'b0;
      end else if (flush_i) begin
         for (int unsigned s = 0; s < NumSets; s++) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
               valid_q[s][w] <= 1'b0;
            end
         end
         pend_valid_q     <= 1'b0;
         pred_hit_o       <= 1'b0;
         pred_hit_shct_o  <= '0;
         pred_miss_o      <= 1'b0;
         pred_miss_shct_o <= '0;
         pred_outcome_o   <= 1'b0;
      end else begin
         pred_hit_o       <= hit;
         pred_hit_shct_o  <= hit ? hit_sig : '0;
         pred_miss_o      <= miss_emit;
         pred_miss_shct_o <= miss_sig;
         pred_outcome_o   <= miss_out;
         pend_valid_q     <= park;
         pend_sig_q       <= park_sig;
         pend_out_q       <= park_out;
         // Later writes win: fill over inv over hit on a shared line.
         if (hit) outcome_q[acc_set_i][acc_way_i] <= 1'b1;
         if (inv_act) valid_q[inv_set_i][inv_way_i] <= 1'b0;
         if (fill_acc) begin
            valid_q[fill_set_i][fill_way_i]   <= 1'b1;
            sig_q[fill_set_i][fill_way_i]     <= fill_sig;
            outcome_q[fill_set_i][fill_way_i] <= 1'b0;
         end
      end
   end

   inv_while_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pend_valid_q && inv_valid_i && !flush_i));

endmodule

// File: tb/tb_wt_dcache_ship_tracker.sv
// Scoreboard bench for wt_dcache_ship_tracker: directed stimulus pushes expected
// events with their due cycle; a negedge monitor pops and compares them.
module tb_wt_dcache_ship_tracker;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush;
   logic        acc_valid;
   logic [7:0]  acc_set;
   logic [1:0]  acc_way;
   logic        fill_valid;
   logic [7:0]  fill_set;
   logic [1:0]  fill_way;
   logic [63:0] fill_pc;
   logic        fill_ready;
   logic        inv_valid;
   logic [7:0]  inv_set;
   logic [1:0]  inv_way;
   logic        p_hit, p_miss, p_out;
   logic [13:0] p_hit_shct, p_miss_shct, p_shct;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [13:0] sig;
      logic        outc;
      int          at;
   } ev_t;

   ev_t hit_q[$];
   ev_t miss_q[$];
   ev_t mon_e;

   wt_dcache_ship_tracker #(.NumSets(256), .NumWays(4)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .flush_i         (flush),
      .acc_valid_i     (acc_valid),
      .acc_set_i       (acc_set),
      .acc_way_i       (acc_way),
      .fill_valid_i    (fill_valid),
      .fill_set_i      (fill_set),
      .fill_way_i      (fill_way),
      .fill_pc_i       (fill_pc),
      .fill_ready_o    (fill_ready),
      .inv_valid_i     (inv_valid),
      .inv_set_i       (inv_set),
      .inv_way_i       (inv_way),
      .pred_hit_o      (p_hit),
      .pred_miss_o     (p_miss),
      .pred_outcome_o  (p_out),
      .pred_hit_shct_o (p_hit_shct),
      .pred_miss_shct_o(p_miss_shct),
      .pred_shct_o     (p_shct)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (hit_q.size() > 0 && hit_q[0].at < cyc) begin
         chk("hit_overdue", 64'(cyc), 64'(hit_q[0].at));
         hit_q.delete(0);
      end
      if (miss_q.size() > 0 && miss_q[0].at < cyc) begin
         chk("miss_overdue", 64'(cyc), 64'(miss_q[0].at));
         miss_q.delete(0);
      end
      if (p_hit) begin
         if (hit_q.size() == 0) chk("hit_unexpected", 64'(p_hit), 64'd0);
         else begin
            mon_e = hit_q.pop_front();
            chk("hit_cycle", 64'(cyc), 64'(mon_e.at));
            chk("hit_shct", 64'(p_hit_shct), 64'(mon_e.sig));
         end
      end else begin
         chk("hit_shct_idle", 64'(p_hit_shct), 64'd0);
      end
      if (p_miss) begin
         if (miss_q.size() == 0) chk("miss_unexpected", 64'(p_miss), 64'd0);
         else begin
            mon_e = miss_q.pop_front();
            chk("miss_cycle", 64'(cyc), 64'(mon_e.at));
            chk("miss_shct", 64'(p_miss_shct), 64'(mon_e.sig));
            chk("miss_outcome", 64'(p_out), 64'(mon_e.outc));
         end
      end else begin
         chk("miss_shct_idle", 64'(p_miss_shct), 64'd0);
         chk("outcome_idle", 64'(p_out), 64'd0);
      end
   end

   task automatic idle_inputs();
      flush = 1'b0;
      acc_valid = 1'b0;  acc_set = '0;  acc_way = '0;
      fill_valid = 1'b0; fill_set = '0; fill_way = '0; fill_pc = '0;
      inv_valid = 1'b0;  inv_set = '0;  inv_way = '0;
   endtask

   task automatic next();
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_fill(input int s, input int w, input logic [63:0] pc);
      fill_valid = 1'b1; fill_set = 8'(s); fill_way = 2'(w); fill_pc = pc;
   endtask

   task automatic do_acc(input int s, input int w);
      acc_valid = 1'b1; acc_set = 8'(s); acc_way = 2'(w);
   endtask

   task automatic do_inv(input int s, input int w);
      inv_valid = 1'b1; inv_set = 8'(s); inv_way = 2'(w);
   endtask

   task automatic exp_hit(input logic [13:0] sig, input int off);
      ev_t e;
      e.sig = sig; e.outc = 1'b0; e.at = cyc + off;
      hit_q.push_back(e);
   endtask

   task automatic exp_miss(input logic [13:0] sig, input logic outc, input int off);
      ev_t e;
      e.sig = sig; e.outc = outc; e.at = cyc + off;
      miss_q.push_back(e);
   endtask

   initial begin
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_hit", 64'(p_hit), 64'd0);
      chk("rst_miss", 64'(p_miss), 64'd0);
      chk("rst_outcome", 64'(p_out), 64'd0);
      chk("rst_hit_shct", 64'(p_hit_shct), 64'd0);
      chk("rst_miss_shct", 64'(p_miss_shct), 64'd0);
      rst_n = 1'b1;
      #1 chk("ready_after_rst", 64'(fill_ready), 64'd1);
      next();

      // Install on empty line, then hit it
      do_fill(3, 1, 64'h0000_1234);
      #1 chk("lookup_sig", 64'(p_shct), 64'h048D);
      next();
      do_acc(3, 1); exp_hit(14'h048D, 1); next();

      // Refill after a hit: outcome 1 with the old signature
      do_fill(3, 1, 64'h0000_5678);
      #1 chk("lookup_sig2", 64'(p_shct), 64'h159E);
      exp_miss(14'h048D, 1'b1, 1); next();

      // Never-hit line evicted
      do_fill(5, 0, 64'h100); next();
      do_fill(5, 0, 64'h200); exp_miss(14'h040, 1'b0, 1); next();

      // Collision: hit A (sig 0x100) and fill evicting B (sig 0x100)
      do_fill(7, 2, 64'h400); next();
      do_fill(8, 3, 64'h0001_0404); next();
      do_acc(7, 2); do_fill(8, 3, 64'h2000);
      #1 chk("ready_pre_collision", 64'(fill_ready), 64'd1);
      exp_hit(14'h100, 1); exp_miss(14'h100, 1'b0, 2); next();
      #1 chk("ready_pending", 64'(fill_ready), 64'd0);
      next();
      #1 chk("ready_drained", 64'(fill_ready), 64'd1);

      // Pending collides again with a new equal-signature hit: held one more cycle
      do_fill(9, 0, 64'h0001_0404); next();
      do_acc(7, 2); do_fill(9, 0, 64'h3000);
      exp_hit(14'h100, 1); exp_miss(14'h100, 1'b0, 3); next();
      do_acc(7, 2); exp_hit(14'h100, 1);
      #1 chk("ready_pending2", 64'(fill_ready), 64'd0);
      next();
      #1 chk("ready_held", 64'(fill_ready), 64'd0);
      next();
      #1 chk("ready_drained2", 64'(fill_ready), 64'd1);

      // Same-line hit and fill: both events together, eviction outcome 1
      do_acc(3, 1); do_fill(3, 1, 64'h1234);
      exp_hit(14'h159E, 1); exp_miss(14'h159E, 1'b1, 1); next();

      // Invalidate, then hit and invalidate the now-invalid line (no events)
      do_inv(5, 0); exp_miss(14'h080, 1'b0, 1); next();
      do_acc(5, 0); next();
      do_inv(5, 0); next();

      // Fill and inv on different lines: fill refused, inv evicts
      do_fill(10, 0, 64'h4000); do_inv(3, 1);
      #1 chk("ready_fill_vs_inv", 64'(fill_ready), 64'd0);
      exp_miss(14'h048D, 1'b0, 1); next();
      do_acc(10, 0); next();

      // Flush: previously valid lines produce nothing
      flush = 1'b1; next();
      do_acc(7, 2); next();
      do_acc(8, 3); next();
      do_acc(9, 0); next();

      // Reset while an eviction is parked: it must never appear
      do_fill(7, 2, 64'h400); next();
      do_fill(8, 3, 64'h0001_0404); next();
      do_acc(7, 2); do_fill(8, 3, 64'h2000); exp_hit(14'h100, 1); next();
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_hit", 64'(p_hit), 64'd0);
      chk("rst_mid_miss", 64'(p_miss), 64'd0);
      chk("rst_mid_hit_shct", 64'(p_hit_shct), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_after_rst2", 64'(fill_ready), 64'd1);
      repeat (5) @(negedge clk);

      chk("hit_q_drained", 64'(hit_q.size()), 64'd0);
      chk("miss_q_drained", 64'(miss_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wt_dcache_ship_tracker.md
WT_DCACHE_SHIP_TRACKER -- requirements
Module: wt_dcache_ship_tracker

Interface
REQ-001 SHALL have parameter NumSets, default 256, number of dcache sets (power of 2, >=2).
REQ-002 SHALL have parameter NumWays, default 4, dcache associativity (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous clear of all line metadata.
REQ-006 SHALL have port acc_valid_i / acc_set_i / acc_way_i  input  1 / log2(NumSets) / log2(NumWays)  load access that hit the given line.
REQ-007 SHALL have port fill_valid_i / fill_set_i / fill_way_i  input  1 / log2(NumSets) / log2(NumWays)  line install request.
REQ-008 SHALL have port fill_pc_i  input  64  PC of the missing load.
REQ-009 SHALL have port fill_ready_o  output  1  fill accepted when fill_valid_i && fill_ready_o.
REQ-010 SHALL have port inv_valid_i / inv_set_i / inv_way_i  input  1 / log2(NumSets) / log2(NumWays)  line invalidation.
REQ-011 SHALL have port pred_hit_o, pred_miss_o, pred_outcome_o  output  1 each  training events to the SHCT predictor.
REQ-012 SHALL have port pred_hit_shct_o, pred_miss_shct_o, pred_shct_o  output  14 each  signatures to the SHCT predictor.

Function
REQ-013 SHALL hold per line (set, way): valid bit, 14-bit signature, outcome bit.
REQ-014 SHALL compute sig(pc) = pc[15:2] XOR pc[29:16].
REQ-015 SHALL drive pred_shct_o = sig(fill_pc_i) combinationally (lookup path, zero latency).
REQ-016 Hit: on acc_valid_i to a valid line, SHALL set its outcome bit to 1 and, next cycle, pulse pred_hit_o for one cycle with pred_hit_shct_o = the line's stored signature.
REQ-017 acc_valid_i to an invalid line SHALL be ignored (no event, no state change).
REQ-018 Accepted fill to a valid line SHALL emit an eviction next cycle: pred_miss_o=1, pred_miss_shct_o = old signature, pred_outcome_o = old outcome OR (same-cycle hit to that line).
REQ-019 Accepted fill SHALL write valid=1, signature=sig(fill_pc_i), outcome=0; fill to an invalid line emits no event.
REQ-020 inv_valid_i on a valid line SHALL clear valid and emit an eviction exactly as REQ-018; on an invalid line, no effect.
REQ-021 Priority on the same line in one cycle: fill > inv > hit for metadata; the hit event is still emitted using the pre-update signature.
REQ-022 Fill and inv to different lines in one cycle: fill_ready_o SHALL be 0 (inv takes the eviction slot).
REQ-023 Collision: if hit and eviction events in the same cycle carry equal signatures, SHALL emit the hit event next cycle and park the eviction in a 1-entry pending register, emitted the following cycle.
REQ-024 While pending is valid: fill_ready_o=0, inv_valid_i SHALL be stalled by upstream (inv ignored if asserted; assertion error in simulation), hits proceed.
REQ-025 Pending eviction SHALL be issued before any new eviction; pending colliding again with a new hit of equal signature SHALL be held one more cycle.
REQ-026 All event outputs SHALL be registered; at most one hit and one eviction event per cycle; pred_*_shct_o = 0 when the corresponding valid output is 0.
REQ-027 flush_i SHALL clear all valid bits, the pending register, and outstanding event outputs next cycle, with no events generated; flush has priority over all inputs.

Reset
REQ-028 On rst_ni low SHALL asynchronously clear all valid/outcome bits, signatures, and pending; pred_hit_o=0, pred_miss_o=0, pred_outcome_o=0, pred_hit_shct_o=0, pred_miss_shct_o=0; fill_ready_o=1 after release.
REQ-029 Reset asserted mid-collision SHALL drop the pending eviction (no event after release).

Verification
REQ-030 Fill set 3 way 1 pc=0x0000_1234 on empty line -> no event; then hit same line -> next cycle pred_hit_o=1, pred_hit_shct_o=0x048D.
REQ-031 Refill set 3 way 1 with a new PC after that hit -> pred_miss_o=1, pred_outcome_o=1, pred_miss_shct_o=0x048D.
REQ-032 Fill to a never-hit valid line -> pred_miss_o=1, pred_outcome_o=0 with the stored signature.
REQ-033 Same-cycle hit (line A) and fill evicting line B, both signature S -> cycle+1 hit event only, cycle+2 miss event S, fill_ready_o=0 during cycle+1.
REQ-034 Same-cycle hit and fill to the same line -> hit event with old signature and eviction with outcome=1 in the same cycle.
REQ-035 flush_i then hit to any previously filled line -> no event; rst_ni low while pending valid -> outputs 0, no late eviction.
